// File: rtl/batch_normalization_controller.sv
// batch_normalization_controller: streams an NHWC feature map through one batch-norm element,
// fetching per-channel parameters and buffering results behind credit-based flow control.
module batch_normalization_controller #(
   parameter int DATA_WIDTH   = 32,
   parameter int CH_W         = 10,
   parameter int PIX_W        = 16,
   parameter int PIPE_LATENCY = 2,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start_i,
   input  logic [CH_W-1:0]       num_channels_i,
   input  logic [PIX_W-1:0]      num_pixels_i,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   output logic                  param_en_o,
   output logic [CH_W-1:0]       param_addr_o,
   output logic [DATA_WIDTH-1:0] bn_data_o,
   input  logic [DATA_WIDTH-1:0] bn_result_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int RW = AW + 1;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t                  state;
   logic [CH_W-1:0]         nc, ch;
   logic [PIX_W-1:0]        np, pix;
   logic [RW-1:0]           reserved, count;
   logic [PIPE_LATENCY:0]   vp;
   logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic                    accept, pop, load, wr, last_ch, last_pix;
   assign s_ready_o    = (state == RUN) && (reserved < RW'(FIFO_DEPTH));
   assign accept       = s_valid_i & s_ready_o;
   assign param_en_o   = accept;
   assign param_addr_o = ch;
   assign last_ch      = ch == nc - CH_W'(1);
   assign last_pix     = pix == np - PIX_W'(1);
   assign wr           = vp[PIPE_LATENCY];
   assign pop          = m_valid_o & m_ready_i;
   // the head register refills from memory whenever it is empty or being consumed
   assign load         = (count != '0) && (!m_valid_o || m_ready_i);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         nc     <= '0;
         np     <= '0;
         ch     <= '0;
         pix    <= '0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_i) begin
               nc  <= num_channels_i;
               np  <= num_pixels_i;
               ch  <= '0;
               pix <= '0;
               if (num_channels_i == '0 || num_pixels_i == '0) begin
                  state  <= DONE;
                  done_o <= 1'b1;
               end else begin
                  state  <= RUN;
                  busy_o <= 1'b1;
               end
            end
            RUN: if (accept) begin
               ch <= last_ch ? '0 : ch + CH_W'(1);
               if (last_ch) pix <= pix + PIX_W'(1);
               if (last_ch && last_pix) state <= DRAIN;
            end
            DRAIN: if (reserved == '0) begin
               state  <= DONE;
               busy_o <= 1'b0;
               done_o <= 1'b1;
            end
            DONE: begin
               state  <= IDLE;
               done_o <= 1'b0;
            end
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bn_data_o <= '0;
         vp        <= '0;
         reserved  <= '0;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         m_data_o  <= '0;
         m_valid_o <= 1'b0;
      end else begin
         if (accept) bn_data_o <= s_data_i;
         vp       <= {vp[PIPE_LATENCY-1:0], accept};
         reserved <= reserved + RW'(accept) - RW'(pop);
         count    <= count + RW'(wr) - RW'(load);
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (load) begin
            rd_ptr    <= rd_ptr + AW'(1);
            m_data_o  <= mem[rd_ptr];
            m_valid_o <= 1'b1;
         end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
         end
      end
   end
   always_ff @(posedge clk) if (wr) mem[wr_ptr] <= bn_result_i;
endmodule

// File: tb/tb_batch_normalization_controller.sv
// tb_batch_normalization_controller: randomized scoreboard bench; the element is modelled as
// result = data + beta[channel] two cycles after its inputs, beta coming from a 1-cycle RAM.
module tb_batch_normalization_controller;
   localparam int DW = 32, CW = 10, PW = 16, PL = 2, FD = 8;
   logic          clk = 0, reset_n = 0, start_i = 0, s_valid_i = 0, m_ready_i = 0;
   logic [CW-1:0] num_channels_i = '0;
   logic [PW-1:0] num_pixels_i = '0;
   logic [DW-1:0] s_data_i = '0, bn_result_i = '0;
   logic          busy_o, done_o, s_ready_o, param_en_o, m_valid_o;
   logic [CW-1:0] param_addr_o;
   logic [DW-1:0] bn_data_o, m_data_o;
   logic [DW-1:0] beta [1024];
   logic [DW-1:0] beta_q = '0, s1 = '0;
   logic [DW-1:0] exp_q [$];
   int checks = 0, errors = 0, cyc = 0;
   int k, nc_m, vpct, rpct, dones, pops, acc_total, pop_total, first_acc, first_mv, frame_len, len1;
   bit any_rdy, pulse_start;

   always #5 clk = ~clk;

   batch_normalization_controller #(.DATA_WIDTH(DW), .CH_W(CW), .PIX_W(PW), .PIPE_LATENCY(PL), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset_n(reset_n), .start_i(start_i), .num_channels_i(num_channels_i),
      .num_pixels_i(num_pixels_i), .busy_o(busy_o), .done_o(done_o), .s_data_i(s_data_i),
      .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .param_en_o(param_en_o),
      .param_addr_o(param_addr_o), .bn_data_o(bn_data_o), .bn_result_i(bn_result_i),
      .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i));

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (param_en_o) beta_q <= beta[param_addr_o];
      s1          <= bn_data_o + beta_q;
      bn_result_i <= s1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && m_valid_o && first_mv < 0) first_mv = cyc;
      if (reset_n && m_valid_o && m_ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_output: got %0h expected none", m_data_o);
         end else chk("out_data", m_data_o, exp_q.pop_front());
         pops++;
         pop_total++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (acc_total - pop_total >= FD) chk("credit_block", s_ready_o, 0);
      start_i     = pulse_start;
      pulse_start = 0;
      s_valid_i   = $urandom_range(99) < vpct;
      s_data_i    = $urandom;
      m_ready_i   = $urandom_range(99) < rpct;
      @(negedge clk);
      if (s_ready_o) any_rdy = 1;
      if (s_valid_i && s_ready_o) begin
         if (k == 0) first_acc = cyc + 1;
         chk("param_en", param_en_o, 1);
         chk("param_addr", param_addr_o, nc_m ? k % nc_m : 0);
         exp_q.push_back(s_data_i + beta[nc_m ? k % nc_m : 0]);
         k++;
         acc_total++;
      end else if (param_en_o) chk("param_en_idle", param_en_o, 0);
      if (done_o) begin
         dones++;
         chk("busy_at_done", busy_o, 0);
      end
   endtask

   task automatic start_frame(input int nc, input int np);
      num_channels_i = CW'(nc);
      num_pixels_i   = PW'(np);
      nc_m = nc; k = 0; dones = 0; pops = 0; any_rdy = 0; first_acc = -1; first_mv = -1;
      pulse_start = 1;
      step();
   endtask

   task automatic finish_frame(input int exp_n);
      int n = 0;
      while (dones == 0 && n < 3000) begin
         step();
         n++;
      end
      frame_len = n;
      repeat (3) step();
      chk("done_once", dones, 1);
      chk("accepted", k, exp_n);
      chk("delivered", pops, exp_n);
      chk("queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      foreach (beta[i]) beta[i] = $urandom;
      vpct = 100; rpct = 100; acc_total = 0; pop_total = 0; pulse_start = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_s_ready", s_ready_o, 0);
      chk("rst_param_en", param_en_o, 0);
      chk("rst_m_valid", m_valid_o, 0);
      chk("rst_param_addr", param_addr_o, 0);
      chk("rst_bn_data", bn_data_o, 0);
      chk("rst_m_data", m_data_o, 0);
      @(negedge clk) reset_n = 1;

      // full-rate small frame
      start_frame(3, 2);
      finish_frame(6);
      chk("first_latency", first_mv - first_acc, 4);
      len1 = frame_len;

      // backpressure fills the credits then releases
      rpct = 0;
      start_frame(4, 8);
      repeat (20) step();
      chk("fill_accepts", k, 8);
      chk("fill_valid", m_valid_o, 1);
      chk("fill_ready_low", s_ready_o, 0);
      rpct = 100;
      finish_frame(32);

      // random gaps on both sides
      vpct = 60; rpct = 60;
      start_frame(4, 4);
      finish_frame(16);

      // empty frame
      vpct = 100; rpct = 100;
      start_frame(0, 5);
      finish_frame(0);
      chk("empty_no_ready", any_rdy, 0);
      chk("empty_done_soon", frame_len <= 2, 1);

      // reset in the middle of a frame
      rpct = 0;
      start_frame(4, 3);
      while (k < 5) step();
      vpct = 0;
      repeat (6) step();
      chk("pre_reset_valid", m_valid_o, 1);
      @(posedge clk);
      #1;
      reset_n = 0;
      #1;
      chk("mid_rst_m_valid", m_valid_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_s_ready", s_ready_o, 0);
      chk("mid_rst_m_data", m_data_o, 0);
      chk("mid_rst_bn_data", bn_data_o, 0);
      exp_q.delete();
      acc_total = 0; pop_total = 0;
      @(negedge clk) reset_n = 1;
      vpct = 100; rpct = 100;
      start_frame(2, 1);
      finish_frame(2);

      // start pulsed during RUN must be ignored
      start_frame(3, 2);
      step();
      num_channels_i = 7;
      num_pixels_i   = 9;
      pulse_start    = 1;
      step();
      step();
      finish_frame(6);
      chk("restart_ignored_len", frame_len + 3, len1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
